// File: rtl/ahb_lite_ram_arbiter.sv
// Two-port AHB-Lite slave sharing one single-port synchronous RAM.
// Each port has one wait state minimum; a round-robin pointer resolves contention.
module ahb_lite_ram_arbiter #(
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,

  input  logic                 HSEL0,
  input  logic                 HWRITE0,
  input  logic [1:0]           HTRANS0,
  input  logic [2:0]           HSIZE0,
  input  logic [2:0]           HBURST0,
  input  logic [31:0]          HADDR0,
  input  logic [DATAWIDTH-1:0] HWDATA0,
  output logic                 HREADYOUT0,
  output logic                 HRESP0,
  output logic [DATAWIDTH-1:0] HRDATA0,

  input  logic                 HSEL1,
  input  logic                 HWRITE1,
  input  logic [1:0]           HTRANS1,
  input  logic [2:0]           HSIZE1,
  input  logic [2:0]           HBURST1,
  input  logic [31:0]          HADDR1,
  input  logic [DATAWIDTH-1:0] HWDATA1,
  output logic                 HREADYOUT1,
  output logic                 HRESP1,
  output logic [DATAWIDTH-1:0] HRDATA1,

  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [2:0]           mem_size,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    PIdle = 3'd0,
    PWait = 3'd1,
    PResp = 3'd2,
    PErr1 = 3'd3,
    PErr2 = 3'd4
  } port_state_e;

  localparam logic [2:0] MaxSize = 3'b010;

  // Per-port views of the AHB inputs
  logic [1:0]           sel_in;
  logic [1:0]           write_in;
  logic [1:0]           active_in;
  logic [2:0]           size_in  [2];
  logic [ADDRWIDTH-1:0] addr_in  [2];
  logic [DATAWIDTH-1:0] wdata_in [2];

  assign sel_in      = {HSEL1, HSEL0};
  assign write_in    = {HWRITE1, HWRITE0};
  assign active_in   = {HTRANS1[1], HTRANS0[1]};
  assign size_in[0]  = HSIZE0;
  assign size_in[1]  = HSIZE1;
  assign addr_in[0]  = HADDR0[ADDRWIDTH-1:0];
  assign addr_in[1]  = HADDR1[ADDRWIDTH-1:0];
  assign wdata_in[0] = HWDATA0;
  assign wdata_in[1] = HWDATA1;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST0, HBURST1, HTRANS0[0], HTRANS1[0],
                           HADDR0[31:ADDRWIDTH], HADDR1[31:ADDRWIDTH]};

  port_state_e          state_q   [2];
  port_state_e          state_d   [2];
  logic [ADDRWIDTH-1:0] addr_q    [2];
  logic [ADDRWIDTH-1:0] addr_d    [2];
  logic [2:0]           size_q    [2];
  logic [2:0]           size_d    [2];
  logic [DATAWIDTH-1:0] rdata_q   [2];
  logic [DATAWIDTH-1:0] rdata_d   [2];
  logic [1:0]           write_q,   write_d;
  logic [1:0]           rd_pend_q, rd_pend_d;
  logic                 rr_ptr_q,  rr_ptr_d;

  logic [1:0]           hready;
  logic [1:0]           hresp;
  logic [1:0]           accept;
  logic [1:0]           waiting;
  logic [1:0]           grant;
  logic [DATAWIDTH-1:0] hrdata [2];

  // Bus-facing status decoded from each port state
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hready[p] = 1'b1;
      hresp[p]  = 1'b0;
      case (state_q[p])
        PWait: hready[p] = 1'b0;
        PErr1: begin
          hready[p] = 1'b0;
          hresp[p]  = 1'b1;
        end
        PErr2:   hresp[p] = 1'b1;
        default: ;
      endcase
      waiting[p] = (state_q[p] == PWait);
      accept[p]  = sel_in[p] & active_in[p] & hready[p];
      // Read data is live from the RAM in the response cycle, held afterwards
      hrdata[p]  = rd_pend_q[p] ? mem_rdata : rdata_q[p];
    end
  end

  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    unique case (waiting)
      2'b01: begin
        grant    = 2'b01;
        rr_ptr_d = 1'b1;
      end
      2'b10: begin
        grant    = 2'b10;
        rr_ptr_d = 1'b0;
      end
      2'b11: begin
        grant    = rr_ptr_q ? 2'b10 : 2'b01;
        rr_ptr_d = ~rr_ptr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = addr_q[0];
    mem_size  = size_q[0];
    mem_wdata = wdata_in[0];
    if (grant[1]) begin
      mem_we    = write_q[1];
      mem_addr  = addr_q[1];
      mem_size  = size_q[1];
      mem_wdata = wdata_in[1];
    end else if (grant[0]) begin
      mem_we = write_q[0];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p]   = state_q[p];
      addr_d[p]    = addr_q[p];
      size_d[p]    = size_q[p];
      write_d[p]   = write_q[p];
      rdata_d[p]   = hrdata[p];
      rd_pend_d[p] = grant[p] & ~write_q[p];
      case (state_q[p])
        PIdle, PResp, PErr2: begin
          if (accept[p]) begin
            addr_d[p]  = addr_in[p];
            size_d[p]  = size_in[p];
            write_d[p] = write_in[p];
            state_d[p] = (size_in[p] <= MaxSize) ? PWait : PErr1;
          end else begin
            state_d[p] = PIdle;
          end
        end
        PWait: begin
          if (grant[p]) state_d[p] = PResp;
        end
        PErr1:   state_d[p] = PErr2;
        default: state_d[p] = PIdle;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= PIdle;
        addr_q[p]  <= '0;
        size_q[p]  <= '0;
        rdata_q[p] <= '0;
      end
      write_q   <= '0;
      rd_pend_q <= '0;
      rr_ptr_q  <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        addr_q[p]  <= addr_d[p];
        size_q[p]  <= size_d[p];
        rdata_q[p] <= rdata_d[p];
      end
      write_q   <= write_d;
      rd_pend_q <= rd_pend_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign HREADYOUT0 = hready[0];
  assign HREADYOUT1 = hready[1];
  assign HRESP0     = hresp[0];
  assign HRESP1     = hresp[1];
  assign HRDATA0    = hrdata[0];
  assign HRDATA1    = hrdata[1];

endmodule

// File: tb/tb_ahb_lite_ram_arbiter.sv
// Directed bench for ahb_lite_ram_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_ahb_lite_ram_arbiter;

  localparam logic [1:0] Idle   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Nonseq = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel   [2];
  logic        hwrite [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [31:0] haddr  [2];
  logic [31:0] hwdata [2];
  logic        hready [2];
  logic        hresp  [2];
  logic [31:0] hrdata [2];

  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram   [1024] = '{default: 32'h0};
  logic [31:0] m_mem [1024] = '{default: 32'h0};

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: pending memory request, error countdown, last read data
  bit          m_pend [2];
  int          m_err  [2];
  logic [9:0]  m_addr [2];
  logic        m_wr   [2];
  logic [2:0]  m_size [2];
  logic [31:0] m_rd   [2];
  bit          m_rr;

  ahb_lite_ram_arbiter #(.ADDRWIDTH(10), .DATAWIDTH(32)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL0      (hsel[0]),
    .HWRITE0    (hwrite[0]),
    .HTRANS0    (htrans[0]),
    .HSIZE0     (hsize[0]),
    .HBURST0    (3'b000),
    .HADDR0     (haddr[0]),
    .HWDATA0    (hwdata[0]),
    .HREADYOUT0 (hready[0]),
    .HRESP0     (hresp[0]),
    .HRDATA0    (hrdata[0]),
    .HSEL1      (hsel[1]),
    .HWRITE1    (hwrite[1]),
    .HTRANS1    (htrans[1]),
    .HSIZE1     (hsize[1]),
    .HBURST1    (3'b001),
    .HADDR1     (haddr[1]),
    .HWDATA1    (hwdata[1]),
    .HREADYOUT1 (hready[1]),
    .HRESP1     (hresp[1]),
    .HRDATA1    (hrdata[1]),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_size   (mem_size),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int srv;
    bit rdy [2];
    if (!HRESETn) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("reset hreadyout%0d", p), {31'd0, hready[p]}, 32'd1);
        chk($sformatf("reset hresp%0d", p), {31'd0, hresp[p]}, 32'd0);
        chk($sformatf("reset hrdata%0d", p), hrdata[p], 32'd0);
        m_pend[p] = 1'b0;
        m_err[p]  = 0;
        m_rd[p]   = 32'd0;
      end
      chk("reset mem_en", {31'd0, mem_en}, 32'd0);
      chk("reset mem_we", {31'd0, mem_we}, 32'd0);
      m_rr = 1'b0;
      return;
    end
    srv = -1;
    if (m_pend[0] && m_pend[1]) srv = m_rr ? 1 : 0;
    else if (m_pend[0])         srv = 0;
    else if (m_pend[1])         srv = 1;
    for (int p = 0; p < 2; p++) begin
      rdy[p] = !(m_pend[p] || m_err[p] == 2);
      chk($sformatf("hreadyout%0d", p), {31'd0, hready[p]}, {31'd0, rdy[p]});
      chk($sformatf("hresp%0d", p), {31'd0, hresp[p]}, {31'd0, m_err[p] != 0});
      chk($sformatf("hrdata%0d", p), hrdata[p], m_rd[p]);
    end
    chk("mem_en", {31'd0, mem_en}, {31'd0, srv >= 0});
    if (srv >= 0) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_wr[srv]});
      chk("mem_addr", {22'd0, mem_addr}, {22'd0, m_addr[srv]});
      chk("mem_size", {29'd0, mem_size}, {29'd0, m_size[srv]});
      if (m_wr[srv]) begin
        chk("mem_wdata", mem_wdata, hwdata[srv]);
        m_mem[m_addr[srv]] = hwdata[srv];
      end else begin
        m_rd[srv] = m_mem[m_addr[srv]];
      end
      m_pend[srv] = 1'b0;
      m_rr        = (srv == 0);
    end else begin
      chk("mem_we idle", {31'd0, mem_we}, 32'd0);
    end
    for (int p = 0; p < 2; p++) begin
      if (m_err[p] > 0) m_err[p]--;
      if (rdy[p] && hsel[p] && htrans[p][1]) begin
        if (hsize[p] <= 3'd2) begin
          m_pend[p] = 1'b1;
          m_addr[p] = haddr[p][9:0];
          m_wr[p]   = hwrite[p];
          m_size[p] = hsize[p];
        end else begin
          m_err[p] = 2;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge HCLK);
      model_step();
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input int p, input logic w, input logic [1:0] t, input logic [2:0] z,
                     input logic [31:0] a);
    hsel[p]   = 1'b1;
    hwrite[p] = w;
    htrans[p] = t;
    hsize[p]  = z;
    haddr[p]  = a;
  endtask

  task automatic idle(input int p);
    hsel[p]   = 1'b0;
    hwrite[p] = 1'b0;
    htrans[p] = Idle;
    hsize[p]  = 3'd0;
    haddr[p]  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    for (int p = 0; p < 2; p++) begin
      idle(p);
      hwdata[p] = 32'd0;
    end
    repeat (3) tick();
    chk("lit reset hreadyout0", {31'd0, hready[0]}, 32'd1);
    chk("lit reset mem_en", {31'd0, mem_en}, 32'd0);

    // Port 0 write then read of 0x010; first accept on first edge out of reset
    tick(); HRESETn = 1'b1; drv(0, 1'b1, Nonseq, 3'd2, 32'h010);
    tick(); idle(0); hwdata[0] = 32'hDEADBEEF;
    #1 chk("A wait hready0", {31'd0, hready[0]}, 32'd0);
    chk("A write mem_we", {31'd0, mem_we}, 32'd1);
    chk("A write addr", {22'd0, mem_addr}, 32'h010);
    tick(); drv(0, 1'b0, Nonseq, 3'd2, 32'h010);
    #1 chk("A write done", {31'd0, hready[0]}, 32'd1);
    tick(); idle(0);
    #1 chk("A read wait", {31'd0, hready[0]}, 32'd0);
    tick();
    #1 chk("A read data", hrdata[0], 32'hDEADBEEF);

    // Simultaneous reads right after reset: port 0 first
    tick(); HRESETn = 1'b0;
    tick(); HRESETn = 1'b1;
    drv(0, 1'b0, Nonseq, 3'd2, 32'h010);
    drv(1, 1'b0, Nonseq, 3'd2, 32'h010);
    tick(); idle(0); idle(1);
    #1 chk("B both wait", {30'd0, hready[1], hready[0]}, 32'd0);
    tick();
    #1 chk("B port0 done first", {30'd0, hready[1], hready[0]}, 32'd1);
    chk("B hrdata0", hrdata[0], 32'hDEADBEEF);
    tick();
    #1 chk("B port1 done", {31'd0, hready[1]}, 32'd1);
    chk("B hrdata1", hrdata[1], 32'hDEADBEEF);

    // Oversized transfer on port 1 -> two-cycle error, no RAM access
    tick(); drv(1, 1'b0, Nonseq, 3'b011, 32'h020);
    tick(); idle(1);
    #1 chk("C err1", {30'd0, hresp[1], hready[1]}, 32'd2);
    chk("C err1 mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    #1 chk("C err2", {30'd0, hresp[1], hready[1]}, 32'd3);
    chk("C err2 mem_en", {31'd0, mem_en}, 32'd0);

    // Same-cycle write (port 0) and read (port 1) of 0x3FF with rr_ptr=0
    tick(); drv(0, 1'b1, Nonseq, 3'd2, 32'h0000F3FF);
    drv(1, 1'b0, Nonseq, 3'd2, 32'h000003FF);
    tick(); idle(0); idle(1); hwdata[0] = 32'hCAFEF00D;
    #1 chk("D write first", {31'd0, mem_we}, 32'd1);
    chk("D wdata", mem_wdata, 32'hCAFEF00D);
    tick();
    #1 chk("D read addr", {22'd0, mem_addr}, 32'h3FF);
    tick();
    #1 chk("D hrdata1", hrdata[1], 32'hCAFEF00D);

    // Back-to-back streams on both ports: grants alternate 0,1,0,1
    tick(); drv(0, 1'b0, Nonseq, 3'd2, 32'h010);
    drv(1, 1'b0, Nonseq, 3'd2, 32'h3FF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        idle(0);
        idle(1);
      end
      #1 chk($sformatf("E grant %0d", k), {21'd0, mem_en, mem_addr},
             (k % 2 == 1) ? 32'h410 : 32'h7FF);
    end
    tick(); tick();
    #1 chk("E hrdata1", hrdata[1], 32'hCAFEF00D);

    // BUSY on port 0 ignored; port 1 write then read of 0x055
    tick(); drv(0, 1'b0, Busy, 3'd2, 32'h010);
    drv(1, 1'b1, Nonseq, 3'd2, 32'h055);
    tick(); idle(0); idle(1); hwdata[1] = 32'h12345678;
    #1 chk("F busy ignored", {31'd0, hready[0]}, 32'd1);
    tick(); drv(1, 1'b0, Nonseq, 3'd2, 32'h055);
    tick(); idle(1);
    tick();
    #1 chk("F hrdata1", hrdata[1], 32'h12345678);

    // Reset while a write is waiting: aborted, RAM unchanged
    tick(); drv(0, 1'b1, Nonseq, 3'd2, 32'h100);
    tick(); idle(0); hwdata[0] = 32'h11112222;
    tick(); drv(0, 1'b1, Nonseq, 3'd2, 32'h100);
    tick(); idle(0); hwdata[0] = 32'hBAD0BAD0;
    #1 chk("G pending", {31'd0, mem_en}, 32'd1);
    HRESETn = 1'b0;
    #1 chk("G rst outs", {28'd0, hresp[0], hready[0], mem_we, mem_en}, 32'h4);
    chk("G rst hrdata0", hrdata[0], 32'd0);
    chk("G rst hrdata1", hrdata[1], 32'd0);
    tick(); tick(); HRESETn = 1'b1;
    drv(0, 1'b0, Nonseq, 3'd2, 32'h100);
    tick(); idle(0);
    tick();
    #1 chk("G hrdata0", hrdata[0], 32'h11112222);
    chk("G ram unchanged", ram[10'h100], 32'h11112222);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
